urom_responder: RTL and testbench

//  Responder end of the CPU microcode-ROM fetch interface. Returns the 24-bit microinstruction
//  and its valid flag in_rom_efficient for the address the CPU sequencer presents on addr_rom.

---
 rtl/urom_responder.sv | 154 +++++++++++++++
 tb/tb_urom_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/urom_responder.sv
`default_nettype none
// ============================================================================
// Module      : urom_responder
// Description : Microcode-ROM responder for the CPU sequencer, with a
//               byte-serial loader that programs the 24-bit store.
// Revision    : 1.0 - initial release
// ============================================================================
module urom_responder #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_rd,
  input  logic [ADDR_W-1:0] addr_rom,
  output logic [WORD_W-1:0] in_rom,
  output logic              in_rom_efficient,
  input  logic              ld_start,
  input  logic [7:0]        ld_byte,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_err,
  output logic [7:0]        ld_sum
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_CNT  = 3'd2,
    S_B2   = 3'd3,
    S_B1   = 3'd4,
    S_B0   = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_wptr;
  logic [8:0]        r_cnt;
  logic [7:0]        r_b2;
  logic [7:0]        r_b1;
  logic [WORD_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  logic w_wr_en;
  logic w_fetch_ok;

  // A fetch is served only if the loader will be idle in the cycle the
  // response is presented, so ld_busy and a valid word never overlap.
  always_comb begin
    w_wr_en    = (r_state == S_B0) && ld_valid;
    w_fetch_ok = ((r_state == S_IDLE) && !ld_start) || (r_state == S_DONE);
  end

  // Store is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wptr] <= {r_b2, r_b1, ld_byte};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_wptr           <= '0;
      r_cnt            <= '0;
      r_b2             <= '0;
      r_b1             <= '0;
      in_rom           <= '0;
      in_rom_efficient <= 1'b0;
      ld_ready         <= 1'b0;
      ld_busy          <= 1'b0;
      ld_done          <= 1'b0;
      ld_err           <= 1'b0;
      ld_sum           <= '0;
    end else begin
      if (w_fetch_ok && rom_rd) begin
        in_rom           <= r_mem[addr_rom];
        in_rom_efficient <= 1'b1;
      end else begin
        in_rom           <= '0;
        in_rom_efficient <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (ld_start) begin
            r_state  <= S_ADDR;
            ld_ready <= 1'b1;
            ld_busy  <= 1'b1;
            ld_sum   <= '0;
            ld_err   <= 1'b0;
          end else if (ld_valid) begin
            ld_err <= 1'b1;
          end
        end
        S_ADDR: begin
          if (ld_valid) begin
            r_wptr  <= ld_byte[ADDR_W-1:0];
            r_state <= S_CNT;
          end
        end
        S_CNT: begin
          if (ld_valid) begin
            // A count byte of zero stands for a full 256-word load.
            r_cnt   <= (ld_byte == 8'd0) ? 9'd256 : {1'b0, ld_byte};
            r_state <= S_B2;
          end
        end
        S_B2: begin
          if (ld_valid) begin
            r_b2    <= ld_byte;
            ld_sum  <= ld_sum + ld_byte;
            r_state <= S_B1;
          end
        end
        S_B1: begin
          if (ld_valid) begin
            r_b1    <= ld_byte;
            ld_sum  <= ld_sum + ld_byte;
            r_state <= S_B0;
          end
        end
        S_B0: begin
          if (ld_valid) begin
            ld_sum <= ld_sum + ld_byte;
            r_wptr <= r_wptr + 1'b1;
            r_cnt  <= r_cnt - 9'd1;
            if (r_cnt == 9'd1) begin
              r_state  <= S_DONE;
              ld_ready <= 1'b0;
              ld_done  <= 1'b1;
            end else begin
              r_state <= S_B2;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          ld_busy <= 1'b0;
          ld_done <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          ld_ready <= 1'b0;
          ld_busy  <= 1'b0;
          ld_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_urom_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_urom_responder
// Description : Directed self-checking bench for urom_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_urom_responder;

  logic        clk;
  logic        rst;
  logic        rom_rd;
  logic [7:0]  addr_rom;
  logic [23:0] in_rom;
  logic        in_rom_efficient;
  logic        ld_start;
  logic [7:0]  ld_byte;
  logic        ld_valid;
  logic        ld_ready;
  logic        ld_busy;
  logic        ld_done;
  logic        ld_err;
  logic [7:0]  ld_sum;

  int          n_tests;
  int          n_fail;
  logic [23:0] exp_mem [256];
  logic [23:0] wbuf    [256];

  urom_responder #(.ADDR_W(8), .WORD_W(24)) dut (
    .clk              (clk),
    .rst              (rst),
    .rom_rd           (rom_rd),
    .addr_rom         (addr_rom),
    .in_rom           (in_rom),
    .in_rom_efficient (in_rom_efficient),
    .ld_start         (ld_start),
    .ld_byte          (ld_byte),
    .ld_valid         (ld_valid),
    .ld_ready         (ld_ready),
    .ld_busy          (ld_busy),
    .ld_done          (ld_done),
    .ld_err           (ld_err),
    .ld_sum           (ld_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic send(input logic [7:0] b, input bit st, input bit stall);
    if (stall) begin
      repeat ($urandom_range(0, 2)) begin
        ld_byte = 8'($urandom);
        @(negedge clk);
      end
    end
    ld_byte  = b;
    ld_valid = 1'b1;
    ld_start = st;
    @(negedge clk);
    ld_valid = 1'b0;
    ld_start = 1'b0;
  endtask

  task automatic fetch_chk(input logic [7:0] a);
    rom_rd   = 1'b1;
    addr_rom = a;
    @(negedge clk);
    chk($sformatf("fetch_valid[%h]", a), in_rom_efficient, 1);
    chk($sformatf("fetch_data[%h]", a), in_rom, exp_mem[a]);
  endtask

  // Loads nw words from wbuf; start_at marks the data-byte index on which a
  // stray ld_start is driven alongside the byte (-1 for none).
  task automatic load(input logic [7:0] a, input logic [7:0] n, input int nw,
                      input bit stall, input int start_at);
    logic [7:0] sum;
    logic [7:0] b;
    logic [7:0] wa;
    bit         seen;
    sum      = 8'd0;
    rom_rd   = 1'b1;
    addr_rom = a;
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    chk("busy_after_start", ld_busy, 1);
    chk("ready_after_start", ld_ready, 1);
    chk("err_cleared", ld_err, 0);
    chk("sum_cleared", ld_sum, 0);
    chk("fetch_refused_valid", in_rom_efficient, 0);
    chk("fetch_refused_data", in_rom, 0);
    send(a, 1'b0, stall);
    send(n, 1'b0, stall);
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < 3; k++) begin
        b = 8'(wbuf[w] >> (16 - 8 * k));
        if (w == nw - 1 && k == 2)
          chk("no_early_done", {ld_done, ld_busy}, 2'b01);
        send(b, (w * 3 + k) == start_at, stall);
        sum = sum + b;
      end
      wa = a + 8'(w);
      exp_mem[wa] = wbuf[w];
    end
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (ld_done) seen = 1'b1;
      else @(negedge clk);
    end
    chk("ld_done_seen", seen, 1);
    chk("ld_sum", ld_sum, sum);
    chk("busy_in_done", ld_busy, 1);
    chk("no_fetch_in_done", in_rom_efficient, 0);
    @(negedge clk);
    chk("done_one_cycle", ld_done, 0);
    chk("idle_after_done", ld_busy, 0);
    chk("sum_held", ld_sum, sum);
    chk("first_fetch_valid", in_rom_efficient, 1);
    chk("first_fetch_data", in_rom, exp_mem[a]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    rom_rd   = 1'b0;
    addr_rom = 8'd0;
    ld_start = 1'b0;
    ld_byte  = 8'd0;
    ld_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values, then an asynchronous mid-cycle reset
    chk("rst_in_rom", in_rom, 0);
    chk("rst_valid", in_rom_efficient, 0);
    chk("rst_ready", ld_ready, 0);
    chk("rst_busy", ld_busy, 0);
    chk("rst_done", ld_done, 0);
    chk("rst_err", ld_err, 0);
    chk("rst_sum", ld_sum, 0);
    rst      = 1'b0;
    rom_rd   = 1'b1;
    ld_valid = 1'b1;
    ld_byte  = 8'h5A;
    @(negedge clk);
    ld_valid = 1'b0;
    chk("pre_rst_valid", in_rom_efficient, 1);
    chk("pre_rst_err", ld_err, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", in_rom_efficient, 0);
    chk("async_rst_err", ld_err, 0);
    chk("async_rst_in_rom", in_rom, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_fetch", in_rom_efficient, 1);

    // Load and read back
    wbuf[0] = 24'h123456;
    wbuf[1] = 24'hABCDEF;
    load(8'h10, 8'd2, 2, 1'b0, -1);
    // 0x12+0x34+0x56+0xAB+0xCD+0xEF = 771 -> 0x03 mod 256
    chk("sum_literal", ld_sum, 8'h03);
    fetch_chk(8'h11);
    chk("rd11_literal", in_rom, 24'hABCDEF);
    fetch_chk(8'h10);
    chk("rd10_literal", in_rom, 24'h123456);
    rom_rd = 1'b0;
    @(negedge clk);
    chk("rom_rd_low_valid", in_rom_efficient, 0);
    chk("rom_rd_low_data", in_rom, 0);

    // Address wrap and full 256-word load
    wbuf[0] = 24'h111111;
    load(8'hFF, 8'd1, 1, 1'b0, -1);
    fetch_chk(8'hFF);
    wbuf[0] = 24'h222222;
    wbuf[1] = 24'h333333;
    load(8'hFF, 8'd2, 2, 1'b0, -1);
    fetch_chk(8'hFF);
    fetch_chk(8'h00);
    chk("wrap_literal", in_rom, 24'h333333);
    for (int i = 0; i < 256; i++)
      wbuf[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h5A};
    load(8'h20, 8'd0, 256, 1'b0, -1);
    fetch_chk(8'h20);
    fetch_chk(8'h1F);
    chk("full_last_literal", in_rom, 24'hFF00A5);
    fetch_chk(8'h00);

    // Randomly stalled load
    wbuf[0] = 24'hC0FFEE;
    wbuf[1] = 24'hBADA55;
    wbuf[2] = 24'h0DDBA1;
    load(8'h40, 8'd3, 3, 1'b1, -1);
    fetch_chk(8'h40);
    fetch_chk(8'h41);
    fetch_chk(8'h42);

    // Byte while idle, then ld_start inside B1
    rom_rd   = 1'b0;
    ld_valid = 1'b1;
    ld_byte  = 8'h77;
    @(negedge clk);
    ld_valid = 1'b0;
    chk("idle_byte_err", ld_err, 1);
    fetch_chk(8'h77);
    chk("err_sticky", ld_err, 1);
    wbuf[0] = 24'h0F1E2D;
    load(8'h50, 8'd1, 1, 1'b0, 1);
    fetch_chk(8'h50);

    // Reset during word 2 of 3
    rom_rd   = 1'b0;
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    send(8'h60, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    send(8'hA1, 1'b0, 1'b0);
    send(8'hA2, 1'b0, 1'b0);
    send(8'hA3, 1'b0, 1'b0);
    send(8'hC1, 1'b0, 1'b0);
    send(8'hC2, 1'b0, 1'b0);
    chk("midload_busy", ld_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("midload_rst_busy", ld_busy, 0);
    chk("midload_rst_ready", ld_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_mem[8'h60] = 24'hA1A2A3;
    fetch_chk(8'h60);
    fetch_chk(8'h61);
    fetch_chk(8'h62);
    chk("after_midload_busy", ld_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
